// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults, typedefs and parity helper for the register file.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DATA_W_DEFAULT   = 64;
    localparam int NUM_REGS_DEFAULT = 32;
    localparam int REG_AW           = $clog2(NUM_REGS_DEFAULT);

    typedef logic [REG_AW-1:0]         reg_addr_t;
    typedef logic [DATA_W_DEFAULT-1:0] reg_data_t;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(reg_data_t d);
        return ^d;
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register busy bits (flush > issue > write) and per-port
//               hazard flags masked by a same-cycle writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = NUM_REGS - 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic                 issue_en,
    input  logic [AW-1:0]        issue_addr,
    input  logic                 flush,
    output logic [NUM_RD-1:0]    rd_busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (r == ZERO_REG) begin
                busy_d[r] = 1'b0;
            end else if (flush) begin
                busy_d[r] = 1'b0;
            end else if (issue_en && issue_addr == AW'(r)) begin
                // A new producer supersedes whichever one is writing back now.
                busy_d[r] = 1'b1;
            end else if (wr_en && wr_addr == AW'(r)) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
        logic [AW-1:0] addr;
        assign addr       = rd_addr[k*AW +: AW];
        assign rd_busy[k] = busy_q[addr] & ~(wr_en && wr_addr == addr);
    end

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_sb
// Description : Multi-port register file with write-first bypass, hardwired
//               zero register and busy scoreboard. Optional read parity is
//               enabled with macro REGFILE_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp_sb #(
    parameter int DATA_W   = regfile_pkg::DATA_W_DEFAULT,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS_DEFAULT,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = NUM_REGS - 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
`ifdef REGFILE_PARITY_EN
    input  logic                     wr_par_flip,
`endif
    input  logic                     issue_en,
    input  logic [AW-1:0]            issue_addr,
    input  logic                     flush,
    output logic [NUM_RD-1:0]        rd_perr
);

    import regfile_pkg::*;

    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wr_ok;

    assign wr_ok = wr_en && (wr_addr != ZERO_A);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

`ifdef REGFILE_PARITY_EN
    logic [NUM_REGS-1:0] par_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_q <= '0;
        end else if (wr_ok) begin
            par_q[wr_addr] <= even_parity(reg_data_t'(wr_data)) ^ wr_par_flip;
        end
    end
`endif

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic          is_zero;
        logic          bypass;

        assign addr    = rd_addr[k*AW +: AW];
        assign is_zero = (addr == ZERO_A);
        assign bypass  = wr_en && (wr_addr == addr);

        assign rd_data[k*DATA_W +: DATA_W] = is_zero ? '0      :
                                             bypass  ? wr_data :
                                                       regs_q[addr];
`ifdef REGFILE_PARITY_EN
        // Only stored data is checked; bypassed and zero reads have no stored copy.
        assign rd_perr[k] = ~is_zero & ~bypass &
                            (even_parity(reg_data_t'(regs_q[addr])) ^ par_q[addr]);
`else
        assign rd_perr[k] = 1'b0;
`endif
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .flush      (flush),
        .rd_busy    (rd_busy)
    );

endmodule : regfile_mp_sb
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp_sb
// Description : Table-driven bench for regfile_mp_sb (2 read ports, 32x64).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp_sb;

    logic         clk = 1'b0;
    logic         reset;
    logic [9:0]   rd_addr;
    logic [127:0] rd_data;
    logic [1:0]   rd_busy;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [63:0]  wr_data;
    logic         issue_en;
    logic [4:0]   issue_addr;
    logic         flush;
    logic [1:0]   rd_perr;
`ifdef REGFILE_PARITY_EN
    logic         wr_par_flip;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    regfile_mp_sb dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
`ifdef REGFILE_PARITY_EN
        .wr_par_flip(wr_par_flip),
`endif
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .flush      (flush),
        .rd_perr    (rd_perr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a0, a1;
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        ie;
        logic [4:0]  ia;
        logic        fl;
        logic [63:0] e0, e1;
        logic [1:0]  eb;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int a0, int a1, bit we, int wa, logic [63:0] wd,
                                bit ie, int ia, bit fl,
                                logic [63:0] e0, logic [63:0] e1, int eb);
        vec_t v;
        v.a0 = 5'(a0); v.a1 = 5'(a1); v.we = we; v.wa = 5'(wa); v.wd = wd;
        v.ie = ie; v.ia = 5'(ia); v.fl = fl;
        v.e0 = e0; v.e1 = e1; v.eb = 2'(eb);
        tbl.push_back(v);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
`ifdef REGFILE_PARITY_EN
        wr_par_flip = 1'b0;
`endif
    endtask

    localparam logic [63:0] DEAD = 64'hDEAD_BEEF_0123_4567;

    initial begin
        reset = 1'b0;
        rd_addr = '0;
        idle_inputs();

        //             a0 a1 we wa wd                      ie ia fl e0     e1     eb
        add( 5,  5, 1,  5, DEAD,                    0,  0, 0, DEAD,  DEAD,  0);
        add( 5,  5, 0,  0, 64'h0,                   0,  0, 0, DEAD,  DEAD,  0);
        add(31,  5, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 0,  0, 0, 64'h0, DEAD,  0);
        add(31, 31, 0,  0, 64'h0,                   1, 31, 0, 64'h0, 64'h0, 0);
        add(31, 31, 0,  0, 64'h0,                   0,  0, 0, 64'h0, 64'h0, 0);
        add( 7,  5, 0,  0, 64'h0,                   1,  7, 0, 64'h0, DEAD,  0);
        add( 7,  5, 0,  0, 64'h0,                   0,  0, 0, 64'h0, DEAD,  1);
        add( 7,  7, 1,  7, 64'h55,                  0,  0, 0, 64'h55, 64'h55, 0);
        add( 7,  7, 0,  0, 64'h0,                   0,  0, 0, 64'h55, 64'h55, 0);
        add( 7,  5, 1,  7, 64'h66,                  1,  7, 0, 64'h66, DEAD,  0);
        add( 7,  7, 0,  0, 64'h0,                   0,  0, 0, 64'h66, 64'h66, 3);
        add( 1,  7, 0,  0, 64'h0,                   1,  1, 0, 64'h0, 64'h66, 2);
        add( 1,  2, 0,  0, 64'h0,                   1,  2, 0, 64'h0, 64'h0, 1);
        add( 2,  3, 0,  0, 64'h0,                   1,  3, 0, 64'h0, 64'h0, 1);
        add( 3,  4, 0,  0, 64'h0,                   1,  4, 1, 64'h0, 64'h0, 1);
        add( 1,  2, 0,  0, 64'h0,                   0,  0, 0, 64'h0, 64'h0, 0);
        add( 3,  4, 0,  0, 64'h0,                   0,  0, 0, 64'h0, 64'h0, 0);
        add( 7,  0, 0,  0, 64'h0,                   0,  0, 0, 64'h66, 64'h0, 0);
        add( 0, 31, 1,  0, 64'h0123,                0,  0, 0, 64'h0123, 64'h0, 0);
        add( 0, 31, 0,  0, 64'h0,                   0,  0, 0, 64'h0123, 64'h0, 0);

        // Held in reset: outputs must already be zero.
        repeat (2) @(negedge clk);
        rd_addr = {5'd5, 5'd7};
        #1;
        check("in_reset_data", rd_data[63:0], 64'h0);
        check("in_reset_busy", 64'(rd_busy), 64'h0);
        reset = 1'b1;

        // Every register reads zero and idle after reset.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rd_addr = {5'(i + 16), 5'(i)};
            #1;
            check($sformatf("rst_p0_r%0d", i),      rd_data[63:0],   64'h0);
            check($sformatf("rst_p1_r%0d", i + 16), rd_data[127:64], 64'h0);
            check($sformatf("rst_busy_%0d", i),     64'(rd_busy),    64'h0);
        end

        foreach (tbl[i]) begin
            @(negedge clk);
            rd_addr    = {tbl[i].a1, tbl[i].a0};
            wr_en      = tbl[i].we;
            wr_addr    = tbl[i].wa;
            wr_data    = tbl[i].wd;
            issue_en   = tbl[i].ie;
            issue_addr = tbl[i].ia;
            flush      = tbl[i].fl;
            #1;
            check($sformatf("v%0d_data0", i), rd_data[63:0],   tbl[i].e0);
            check($sformatf("v%0d_data1", i), rd_data[127:64], tbl[i].e1);
            check($sformatf("v%0d_busy", i),  64'(rd_busy),    64'(tbl[i].eb));
            check($sformatf("v%0d_perr", i),  64'(rd_perr),    64'h0);
        end

        // Asynchronous reset in the middle of operation.
        @(negedge clk);
        idle_inputs();
        issue_en = 1'b1; issue_addr = 5'd5;
        @(negedge clk);
        idle_inputs();
        rd_addr = {5'd5, 5'd5};
        #1;
        check("pre_rst_busy", 64'(rd_busy),   64'h3);
        check("pre_rst_data", rd_data[63:0],  DEAD);
        #1 reset = 1'b0;
        #1;
        check("async_rst_data", rd_data[63:0], 64'h0);
        check("async_rst_busy", 64'(rd_busy),  64'h0);
        @(negedge clk);
        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hABC;
        rd_addr = {5'd5, 5'd6};
        #1;
        check("post_rst_bypass", rd_data[127:64], 64'hABC);
        @(negedge clk);
        idle_inputs();
        rd_addr = {5'd5, 5'd5};
        #1;
        check("post_rst_write", rd_data[63:0], 64'hABC);

`ifdef REGFILE_PARITY_EN
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h3; wr_par_flip = 1'b1;
        rd_addr = {5'd9, 5'd9};
        #1;
        check("par_bypass_perr", 64'(rd_perr), 64'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("par_flip_perr", 64'(rd_perr), 64'h3);
        check("par_flip_data", rd_data[63:0], 64'h3);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h7; wr_par_flip = 1'b0;
        @(negedge clk);
        idle_inputs();
        #1;
        check("par_clean_perr", 64'(rd_perr), 64'h0);
        check("par_clean_data", rd_data[63:0], 64'h7);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_regfile_mp_sb
`default_nettype wire
